// File: rtl/mdc_commutator_stage.sv
// MDC radix-2 commutator: delay lines swap pair halves across 2*DELAY steps,
// with frame sequencing and an automatic drain of the last frame's tail.
module mdc_commutator_stage #(
    parameter int WIDTH = 12,
    parameter int DELAY = 32,
    parameter int FRAME = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mode,
    input  logic             en,
    input  logic [WIDTH-1:0] i1,
    input  logic [WIDTH-1:0] i2,
    output logic             ready,
    output logic [WIDTH-1:0] o1,
    output logic [WIDTH-1:0] o2,
    output logic             o_valid,
    output logic             done
);
    localparam int SW = $clog2(2 * DELAY);
    localparam int SB = $clog2(DELAY);
    localparam int FW = (FRAME > 1) ? $clog2(FRAME) : 1;
    localparam int DW = (DELAY > 1) ? $clog2(DELAY) : 1;
    localparam logic [FW-1:0] F_LAST = FW'(FRAME - 1);
    localparam logic [DW-1:0] D_LAST = DW'(DELAY - 1);

    typedef enum logic [1:0] {IDLE, FILL, TAIL, DRAIN} state_e;
    state_e state_q, state_d;

    logic [SW-1:0]    st_q;
    logic [FW-1:0]    fcnt_q, ocnt_q;
    logic [DW-1:0]    dcnt_q;
    logic             fm_q;
    logic [WIDTH-1:0] ld_q [DELAY];
    logic [WIDTH-1:0] td_q [DELAY];
    logic [DELAY-1:0] tv_q, tm_q;
    logic [WIDTH-1:0] o1_q, o2_q;
    logic             ov_q, done_q;

    logic             accept, dstep, adv, last_drain;
    logic             fm, s, tv, om;
    logic [WIDTH-1:0] a, b, top, bot, ld, td;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept) state_d = FILL;
            FILL:    if (accept && fcnt_q == F_LAST) state_d = TAIL;
            TAIL: begin
                if (accept)          state_d = FILL;
                else if (last_drain) state_d = IDLE;
                else                 state_d = DRAIN;
            end
            DRAIN:   if (last_drain) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // dcnt_q is zero in TAIL, so a single compare covers DELAY=1 too
    always_comb begin
        ready      = (state_q != DRAIN);
        accept     = en & ready;
        dstep      = (state_q == DRAIN) | ((state_q == TAIL) & ~en);
        adv        = accept | dstep;
        last_drain = dstep & (dcnt_q == D_LAST);
    end

    always_comb begin
        fm  = (accept && fcnt_q == '0) ? mode : fm_q;
        a   = dstep ? '0 : (fm ? i2 : i1);
        b   = dstep ? '0 : (fm ? i1 : i2);
        s   = st_q[SB];
        ld  = ld_q[DELAY-1];
        td  = td_q[DELAY-1];
        top = s ? ld : a;
        bot = s ? a : ld;
        tv  = tv_q[DELAY-1];
        om  = tm_q[DELAY-1];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_q   <= '0;
            fcnt_q <= '0;
            dcnt_q <= '0;
            fm_q   <= 1'b0;
        end else if (adv) begin
            st_q <= last_drain ? '0 : st_q + SW'(1);
            if (accept) begin
                fcnt_q <= (fcnt_q == F_LAST) ? '0 : fcnt_q + FW'(1);
                fm_q   <= fm;
            end
            if (dstep) dcnt_q <= last_drain ? '0 : dcnt_q + DW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DELAY; i++) begin
                ld_q[i] <= '0;
                td_q[i] <= '0;
                tv_q[i] <= 1'b0;
                tm_q[i] <= 1'b0;
            end
        end else if (adv) begin
            ld_q[0] <= b;
            td_q[0] <= top;
            tv_q[0] <= accept;
            tm_q[0] <= fm;
            for (int i = 1; i < DELAY; i++) begin
                ld_q[i] <= ld_q[i-1];
                td_q[i] <= td_q[i-1];
                tv_q[i] <= tv_q[i-1];
                tm_q[i] <= tm_q[i-1];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o1_q   <= '0;
            o2_q   <= '0;
            ov_q   <= 1'b0;
            done_q <= 1'b0;
            ocnt_q <= '0;
        end else begin
            ov_q   <= adv & tv;
            done_q <= adv & tv & (ocnt_q == F_LAST);
            if (adv) begin
                o1_q <= om ? bot : td;
                o2_q <= om ? td : bot;
                if (tv) ocnt_q <= (ocnt_q == F_LAST) ? '0 : ocnt_q + FW'(1);
            end
        end
    end

    assign o1      = o1_q;
    assign o2      = o2_q;
    assign o_valid = ov_q;
    assign done    = done_q;
endmodule

// File: tb/tb_mdc_commutator_stage.sv
// Bench for mdc_commutator_stage: three configurations (DELAY 1/2/4)
// checked against directed tables and a block-level reordering model.
module tb_mdc_commutator_stage;
    localparam int DLY [3] = '{1, 2, 4};
    localparam int FRM [3] = '{2, 4, 8};

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        mode_s [3];
    logic        en_s   [3];
    logic        rdy_s  [3];
    logic        ov_s   [3];
    logic        dn_s   [3];
    logic [11:0] i1_s   [3];
    logic [11:0] i2_s   [3];
    logic [11:0] o1_s   [3];
    logic [11:0] o2_s   [3];

    mdc_commutator_stage #(.WIDTH(12), .DELAY(1), .FRAME(2)) u_d1 (
        .clk(clk), .rst(rst), .mode(mode_s[0]), .en(en_s[0]),
        .i1(i1_s[0]), .i2(i2_s[0]), .ready(rdy_s[0]), .o1(o1_s[0]),
        .o2(o2_s[0]), .o_valid(ov_s[0]), .done(dn_s[0]));

    mdc_commutator_stage #(.WIDTH(12), .DELAY(2), .FRAME(4)) u_d2 (
        .clk(clk), .rst(rst), .mode(mode_s[1]), .en(en_s[1]),
        .i1(i1_s[1]), .i2(i2_s[1]), .ready(rdy_s[1]), .o1(o1_s[1]),
        .o2(o2_s[1]), .o_valid(ov_s[1]), .done(dn_s[1]));

    mdc_commutator_stage #(.WIDTH(12), .DELAY(4), .FRAME(8)) u_d4 (
        .clk(clk), .rst(rst), .mode(mode_s[2]), .en(en_s[2]),
        .i1(i1_s[2]), .i2(i2_s[2]), .ready(rdy_s[2]), .o1(o1_s[2]),
        .o2(o2_s[2]), .o_valid(ov_s[2]), .done(dn_s[2]));

    int total = 0;
    int pass  = 0;
    logic [24:0] obs [$];
    logic [24:0] exq [$];
    logic [24:0] acc [$];
    int          vt  [$];
    int   acc_n, it, rdy_low, stray;
    logic fm_m;

    function automatic logic [11:0] rnd12();
        return 12'($urandom);
    endfunction

    task automatic clear();
        obs.delete();
        acc.delete();
        vt.delete();
        acc_n   = 0;
        it      = 0;
        rdy_low = 0;
        stray   = 0;
        fm_m    = 1'b0;
    endtask

    // one clock: drive inputs, log accepted pairs and emitted outputs
    task automatic tick(input int n, input logic e, input logic [11:0] a,
                        input logic [11:0] b, input logic m);
        en_s[n]   = e;
        i1_s[n]   = a;
        i2_s[n]   = b;
        mode_s[n] = m;
        if (!rdy_s[n]) rdy_low++;
        if (e && rdy_s[n]) begin
            if (acc_n % FRM[n] == 0) fm_m = m;
            acc.push_back({fm_m, a, b});
            acc_n++;
        end
        @(posedge clk);
        #1;
        if (ov_s[n]) begin
            obs.push_back({dn_s[n], o1_s[n], o2_s[n]});
            vt.push_back(it);
        end else if (dn_s[n]) begin
            stray++;
        end
        it++;
        en_s[n] = 1'b0;
    endtask

    // each block of 2*D pairs x/y leaves as (x[j],x[j+D]) then (y[j],y[j+D])
    function automatic void build(input int n);
        int d  = DLY[n];
        int oi = 0;
        logic m, dn;
        logic [11:0] x0, x1, y0, y1;
        exq.delete();
        for (int base = 0; base + 2 * d <= acc.size(); base += 2 * d) begin
            m = acc[base][24];
            for (int h = 0; h < 2; h++) begin
                for (int j = 0; j < d; j++) begin
                    x0 = acc[base+j][23:12];
                    x1 = acc[base+j+d][23:12];
                    y0 = acc[base+j][11:0];
                    y1 = acc[base+j+d][11:0];
                    dn = ((oi % FRM[n]) == FRM[n] - 1);
                    if (h == 0) exq.push_back(m ? {dn, y1, y0} : {dn, x0, x1});
                    else        exq.push_back(m ? {dn, x1, x0} : {dn, y0, y1});
                    oi++;
                end
            end
        end
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        #1;
        for (int n = 0; n < 3; n++) begin
            total++;
            if ({ov_s[n], dn_s[n], o1_s[n], o2_s[n]} !== 26'd0)
                $display("FAIL reset_out[%0d] got %h want 0", n,
                         {ov_s[n], dn_s[n], o1_s[n], o2_s[n]});
            else pass++;
            total++;
            if (rdy_s[n] !== 1'b1)
                $display("FAIL reset_ready[%0d] got %b want 1", n, rdy_s[n]);
            else pass++;
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_d1();
        logic [24:0] ex [4];
        ex[0] = {1'b0, 12'd1, 12'd3};
        ex[1] = {1'b1, 12'd2, 12'd4};
        ex[2] = {1'b0, 12'd4, 12'd2};
        ex[3] = {1'b1, 12'd3, 12'd1};
        for (int r = 0; r < 2; r++) begin
            clear();
            tick(0, 1'b1, 12'd1, 12'd2, r[0]);
            tick(0, 1'b1, 12'd3, 12'd4, 1'b0);
            repeat (3) tick(0, 1'b0, rnd12(), rnd12(), 1'b1);
            total++;
            if (obs.size() != 2)
                $display("FAIL d1_count[%0d] got %0d want 2", r, obs.size());
            else pass++;
            for (int k = 0; k < obs.size() && k < 2; k++) begin
                total++;
                if (obs[k] !== ex[2*r+k])
                    $display("FAIL d1_pair[%0d.%0d] got %h want %h", r, k,
                             obs[k], ex[2*r+k]);
                else pass++;
                total++;
                if (vt[k] != k + 1)
                    $display("FAIL d1_cycle[%0d.%0d] got %0d want %0d", r, k,
                             vt[k] + 1, k + 2);
                else pass++;
            end
            total++;
            if (rdy_low != 0 || stray != 0)
                $display("FAIL d1_ready got low=%0d stray=%0d want 0", rdy_low, stray);
            else pass++;
        end
    endtask

    task automatic test_stall(input string tag);
        logic [24:0] ex [4];
        ex[0] = {1'b0, 12'd1, 12'd5};
        ex[1] = {1'b0, 12'd3, 12'd7};
        ex[2] = {1'b0, 12'd2, 12'd6};
        ex[3] = {1'b1, 12'd4, 12'd8};
        clear();
        tick(1, 1'b1, 12'd1, 12'd2, 1'b0);
        tick(1, 1'b1, 12'd3, 12'd4, 1'b0);
        repeat (3) tick(1, 1'b0, rnd12(), rnd12(), 1'b1);
        tick(1, 1'b1, 12'd5, 12'd6, 1'b1);
        tick(1, 1'b1, 12'd7, 12'd8, 1'b0);
        repeat (4) tick(1, 1'b0, rnd12(), rnd12(), 1'b0);
        total++;
        if (obs.size() != 4)
            $display("FAIL %s_count got %0d want 4", tag, obs.size());
        else pass++;
        for (int k = 0; k < obs.size() && k < 4; k++) begin
            total++;
            if (obs[k] !== ex[k])
                $display("FAIL %s_pair[%0d] got %h want %h", tag, k, obs[k], ex[k]);
            else pass++;
            total++;
            if (vt[k] != k + 5)
                $display("FAIL %s_cycle[%0d] got %0d want %0d", tag, k, vt[k], k + 5);
            else pass++;
        end
    endtask

    task automatic test_reset_mid();
        clear();
        tick(1, 1'b1, 12'd9, 12'd10, 1'b0);
        tick(1, 1'b1, 12'd11, 12'd12, 1'b0);
        tick(1, 1'b1, 12'd13, 12'd14, 1'b0);
        total++;
        if (obs.size() != 1 || obs[0] !== {1'b0, 12'd9, 12'd13})
            $display("FAIL pre_rst_out got n=%0d want one pair 009/00d", obs.size());
        else pass++;
        #2 rst = 1'b1;
        #1;
        total++;
        if ({ov_s[1], dn_s[1], o1_s[1], o2_s[1]} !== 26'd0)
            $display("FAIL async_rst_out got %h want 0",
                     {ov_s[1], dn_s[1], o1_s[1], o2_s[1]});
        else pass++;
        #2 rst = 1'b0;
        test_stall("after_rst");
    endtask

    task automatic test_back_to_back();
        int r0;
        int dv [$];
        clear();
        repeat (16) tick(2, 1'b1, rnd12(), rnd12(), 1'($urandom));
        r0 = rdy_low;
        repeat (8) tick(2, 1'b0, rnd12(), rnd12(), 1'($urandom));
        total++;
        if (r0 != 0) $display("FAIL b2b_ready got low=%0d want 0", r0);
        else pass++;
        total++;
        if (vt.size() != 16 || vt[0] != 4 || vt[15] != 19)
            $display("FAIL b2b_span got n=%0d want 16 valid at 4..19", vt.size());
        else pass++;
        for (int k = 0; k < obs.size(); k++) if (obs[k][24]) dv.push_back(vt[k]);
        total++;
        if (dv.size() != 2 || dv[1] - dv[0] != 8)
            $display("FAIL b2b_done got n=%0d want 2 pulses 8 apart", dv.size());
        else pass++;
        build(2);
        total++;
        if (obs.size() != exq.size())
            $display("FAIL b2b_count got %0d want %0d", obs.size(), exq.size());
        else pass++;
        for (int k = 0; k < obs.size() && k < exq.size(); k++) begin
            total++;
            if (obs[k] !== exq[k])
                $display("FAIL b2b_pair[%0d] got %h want %h", k, obs[k], exq[k]);
            else pass++;
        end
    endtask

    task automatic test_drain_en();
        int r0;
        clear();
        repeat (8) tick(2, 1'b1, rnd12(), rnd12(), 1'($urandom));
        tick(2, 1'b0, rnd12(), rnd12(), 1'b0);
        r0 = rdy_low;
        repeat (11) tick(2, 1'b1, rnd12(), rnd12(), 1'($urandom));
        total++;
        if (rdy_low - r0 != 3)
            $display("FAIL drain_ready_low got %0d want 3", rdy_low - r0);
        else pass++;
        total++;
        if (acc_n != 16) $display("FAIL drain_accepts got %0d want 16", acc_n);
        else pass++;
        repeat (8) tick(2, 1'b0, rnd12(), rnd12(), 1'b0);
        build(2);
        total++;
        if (obs.size() != exq.size())
            $display("FAIL drain_count got %0d want %0d", obs.size(), exq.size());
        else pass++;
        for (int k = 0; k < obs.size() && k < exq.size(); k++) begin
            total++;
            if (obs[k] !== exq[k])
                $display("FAIL drain_pair[%0d] got %h want %h", k, obs[k], exq[k]);
            else pass++;
        end
    endtask

    task automatic test_random();
        int guard = 0;
        clear();
        repeat (300)
            tick(2, $urandom_range(0, 9) < 7, rnd12(), rnd12(), 1'($urandom));
        while (acc_n % 8 != 0 && guard < 40) begin
            tick(2, 1'b1, rnd12(), rnd12(), 1'($urandom));
            guard++;
        end
        repeat (12) tick(2, 1'b0, rnd12(), rnd12(), 1'b0);
        build(2);
        total++;
        if (obs.size() != exq.size() || acc_n % 8 != 0)
            $display("FAIL rand_count got %0d want %0d", obs.size(), exq.size());
        else pass++;
        total++;
        if (stray != 0) $display("FAIL rand_stray_done got %0d want 0", stray);
        else pass++;
        for (int k = 0; k < obs.size() && k < exq.size(); k++) begin
            total++;
            if (obs[k] !== exq[k])
                $display("FAIL rand_pair[%0d] got %h want %h", k, obs[k], exq[k]);
            else pass++;
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b0;
        for (int n = 0; n < 3; n++) begin
            en_s[n]   = 1'b0;
            mode_s[n] = 1'b0;
            i1_s[n]   = '0;
            i2_s[n]   = '0;
        end
        clear();
        #1;
        test_reset();
        test_d1();
        test_stall("stall");
        test_reset_mid();
        test_back_to_back();
        test_drain_en();
        test_random();
        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end
endmodule

// File: doc/mdc_commutator_stage.md
MDC_COMMUTATOR_STAGE -- requirements
Module: mdc_commutator_stage

Interface
REQ-001 SHALL provide parameter WIDTH, default 12: coefficient width.
REQ-002 SHALL provide parameter DELAY, default 32: commutator delay in steps; power of two, >=1.
REQ-003 SHALL provide parameter FRAME, default 64: pairs per frame; a multiple of 2*DELAY.
REQ-004 SHALL provide ports:
- clk  in  1  single clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- mode  in  1  0 = forward (NTT) ordering, 1 = inverse (INTT) ordering.
- en  in  1  input pair valid.
- i1, i2  in  WIDTH  input pair.
- ready  out  1  input pair accepted when en=1 and ready=1.
- o1, o2  out  WIDTH  output pair, registered.
- o_valid  out  1  output pair valid, registered.
- done  out  1  one-cycle pulse with the last output pair of a frame.

Function
REQ-005 Definitions:
- step = clock edge with adv=1, where adv = (en & ready) | drain-step.
- st = step counter mod 2*DELAY.
- s = st bit log2(DELAY).
- fm = mode of the frame being accepted.
REQ-006 FSM SHALL have states IDLE, FILL, TAIL, DRAIN with these transitions:
- IDLE->FILL on accept.
- FILL->TAIL on accepting pair FRAME-1.
- TAIL: accept -> FILL (contiguous next frame); en=0 -> drain-step, then DRAIN (IDLE if DELAY=1).
- DRAIN: drain-step every cycle; -> IDLE after DELAY total drain-steps, clearing st to 0 on that step.
REQ-007 ready SHALL be 0 only in DRAIN; en in DRAIN SHALL be ignored (pair dropped, no state change).
REQ-008 en=0 in FILL SHALL stall: no step, all datapath and counter state held, o_valid=0, o1/o2 hold.
REQ-009 fm SHALL be sampled from mode when accepting pair 0 of a frame; mode changes mid-frame SHALL have no effect.
REQ-010 Per step, inputs (a,b) SHALL be:
- (i1,i2) if fm=0, (i2,i1) if fm=1.
- Forced to (0,0) on drain-steps.
REQ-011 Per step, datapath SHALL be:
- LD = b delayed DELAY steps.
- If s=0: top=a, bot=LD; if s=1: top=LD, bot=a.
- TD = top delayed DELAY steps.
- Raw pair = (TD, bot).
REQ-012 A {valid, fm} tag line of DELAY steps SHALL accompany the data. Output mode om = delayed fm. Output pair SHALL be (o1,o2) = (TD,bot) if om=0, or (bot,TD) if om=1.
REQ-013 Output registers SHALL load on every step. o_valid SHALL be 1 for the cycle after a step whose delayed valid tag is 1, else 0.
REQ-014 Latency:
- The pair for step k is presented in the cycle after step k.
- The first valid output of a frame follows input step DELAY, i.e. DELAY+1 cycles after the first accept with continuous en.
REQ-015 An output counter SHALL count valid outputs mod FRAME. done=1 together with o_valid for count FRAME-1, else 0.
REQ-016 Back-to-back frames (accept in TAIL) SHALL insert no bubble. The previous frame's tail SHALL emerge on the new frame's steps and stall with it.
REQ-017 Delay lines SHALL be register/SRL shift lines advancing only on steps; no arithmetic is performed, and widths are preserved exactly.

Reset
REQ-018 rst=1 SHALL asynchronously clear:
- state to IDLE;
- st, the frame, output and drain counters;
- the delay and tag lines;
- fm;
- o1=o2=0, o_valid=0, done=0, ready=1.
REQ-019 rst asserted mid-frame or mid-drain SHALL discard all in-flight data. After release, the first accept SHALL be pair 0 of a new frame.

Verification
REQ-020 DELAY=1, FRAME=2, mode=0: en in cycles 0-1 with (1,2),(3,4), then en=0 -> o_valid in cycles 2-3 with (1,3),(2,4); done in cycle 3; ready stays 1.
REQ-021 Same stimulus with mode=1 -> (4,2) then (3,1); mode toggled in cycle 1 -> output unchanged.
REQ-022 DELAY=2, FRAME=4, mode=0: pairs (1,2),(3,4),(5,6),(7,8) with en low for 3 cycles after pair 1 -> (1,5),(3,7),(2,6),(4,8); o_valid low only during the stall; done with (4,8).
REQ-023 DELAY=4, FRAME=8: two frames on continuous en -> 16 consecutive valid outputs; done pulses exactly 8 cycles apart; ready never low.
REQ-024 DELAY=4: en held high during DRAIN -> ready=0 for exactly 3 cycles, those pairs ignored; next accept after IDLE produces output bit-identical to a frame fed after a gap.
REQ-025 rst pulse mid-frame -> all outputs 0 asynchronously; a fresh frame afterwards matches the REQ-022 expected sequence.
